// File: rtl/dmem_responder.sv
// Data-memory target with programmable wait states and valid/ready request/response handshakes.
// Optional misaligned-access check is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StExec, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            write_q;
    logic [31:0]     wdata_q;
    logic [AW-1:0]   idx_q;
    logic            mis_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [31:0]     resp_rdata_q;
    logic [31:0]     mem [DEPTH_WORDS];
    logic            accept;
    logic            exec;
    logic            resp_done;
    logic            misaligned_in;
    logic            unused_addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned_in = (req_addr[1:0] != 2'b00);
    assign unused_addr   = ^req_addr[31:AW+2];
`else
    // Byte offset is ignored: every access is a full word access to idx.
    assign misaligned_in = 1'b0;
    assign unused_addr   = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        exec      = 1'b0;
        resp_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StExec;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StExec;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StExec: begin
                exec    = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    resp_done = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            wdata_q      <= 32'd0;
            idx_q        <= '0;
            mis_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= req_write;
                wdata_q <= req_wdata;
                idx_q   <= req_addr[AW+1:2];
                mis_q   <= misaligned_in;
            end
            if (exec) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= mis_q;
                resp_rdata_q <= (write_q || mis_q) ? 32'd0 : mem[idx_q];
            end
            if (resp_done) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    // Array is deliberately not reset; a store commits only on its EXEC edge.
    always_ff @(posedge clk) begin
        if (exec && write_q && !mis_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, hand-written corner sequences and a randomized
// run against an array-based reference model; second instance covers zero wait states.
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid = 1'b0, z_req_ready, z_req_write = 1'b0;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic        z_resp_valid, z_resp_ready = 1'b0, z_resp_err;
    logic [31:0] z_resp_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    function automatic bit mis(input logic [31:0] a);
        return ALIGN && (a[1:0] != 2'b00);
    endfunction

    // Counts edges after an accept edge until resp_valid is seen; req_ready must stay low.
    task automatic wait_resp(input string tag, output int lat);
        lat = 0;
        while (!resp_valid && lat < 50) begin
            chk({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(W + 1));
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int stall, input string tag,
                           output logic [31:0] rdata, output logic err);
        int lat;
        chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Junk on the request bus must be ignored while busy.
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        wait_resp(tag, lat);
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, " stall valid"}, 32'(resp_valid), 32'd1);
            chk({tag, " stall rdata"}, resp_rdata, rdata);
            chk({tag, " stall err"}, 32'(resp_err), 32'(err));
            chk({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, " valid drop"}, 32'(resp_valid), 32'd0);
        chk({tag, " ready rise"}, 32'(req_ready), 32'd1);
        if (wr && !mis(addr)) begin
            mdl_mem[widx(addr)]   = wdata;
            mdl_known[widx(addr)] = 1'b1;
        end
    endtask

    task automatic model_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input int stall);
        logic [31:0] rd, exp_rd;
        logic        er;
        bit          known;
        exp_rd = (wr || mis(addr)) ? 32'd0 : mdl_mem[widx(addr)];
        known  = wr || mis(addr) || mdl_known[widx(addr)];
        run_txn(wr, addr, wdata, stall, "rand", rd, er);
        chk("rand err", 32'(er), 32'(mis(addr)));
        if (known) chk("rand rdata", rd, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0400, 32'h0000_0011, 32'h0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0011, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0006, 32'h0000_0055, 32'h0, ALIGN};
        vecs[5] = '{1'b0, 32'h0000_0004, 32'h0, ALIGN ? 32'hDEAD_BEEF : 32'h0000_0055, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 32'h0, 1'b0};
        vecs[7] = '{1'b0, 32'hFFFF_F7FC, 32'h0, 32'h1234_5678, 1'b0};

        #2;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, i % 2, $sformatf("vec%0d", i),
                    rd, er);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Backpressure: five cycles of resp_ready low on a load.
        run_txn(1'b0, 32'h0000_0000, 32'h0, 5, "bp", rd, er);
        chk("bp rdata", rd, 32'h0000_0011);

        // Response handshake and new request in the same cycle: accept is deferred one cycle.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_03FC;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("ovl first", lat);
        chk("ovl first rdata", resp_rdata, 32'h1234_5678);
        resp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0400;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("ovl valid drop", 32'(resp_valid), 32'd0);
        chk("ovl not accepted", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("ovl second", lat);
        chk("ovl second rdata", resp_rdata, 32'h0000_0011);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Reset in the middle of a store's wait states: the store must not land.
        run_txn(1'b1, 32'h0000_0010, 32'hCAFE_0001, 0, "rst pre", rd, er);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst req_ready", 32'(req_ready), 32'd1);
        chk("midrst resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst resp_rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("postrst resp_valid", 32'(resp_valid), 32'd0);
        end
        run_txn(1'b0, 32'h0000_0010, 32'h0, 0, "rst load", rd, er);
        chk("rst load rdata", rd, 32'hCAFE_0001);

        // Zero wait states, requests held and resp_ready tied high: accept every third edge.
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h0000_0008;
        z_req_wdata = 32'h0000_00A5; z_resp_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (i == 1) z_req_write = 1'b0;
            chk($sformatf("w0 ready e%0d", i), 32'(z_req_ready), 32'(i % 3 == 0));
            chk($sformatf("w0 valid e%0d", i), 32'(z_resp_valid), 32'(i % 3 == 2));
            if (i % 3 == 2)
                chk($sformatf("w0 rdata e%0d", i), z_resp_rdata, (i == 2) ? 32'h0 : 32'hA5);
        end
        z_req_valid = 1'b0; z_resp_ready = 1'b0;

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
            model_txn(1'($urandom), a, $urandom, int'($urandom_range(2, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
